bidir_pad_bank: RTL and testbench
=================================

// Module: bidir_pad_bank
// PURPOSE
//  Parametrised bank of WIDTH registered bidirectional pad cells, sharing one drive-enable request.
//  Adds to the single-bit pad cell: a bus-turnaround state machine, an optional bus keeper,
//    a NAND-tree test chain across all bits, and contention detection with a saturating counter.
//  Sits between Slipstream core data buses and the top-level pad emulation on MasterClock.
// PARAMETERS
//  WIDTH        8   pad bits in the bank (>=1)
//  TURN_CYCLES  1   idle cycles inserted at each drive on/off turnaround (0..15)
//  KEEPER       1   1: hold last resolved value while the bus floats; 0: pass pad_in through
//  CNT_W        8   width of the contention counter
// PORTS
//  MasterClock  in   1        sole clock, all state updates on rising edge
//  reset        in   1        synchronous, active-high
//  pad_in       in   WIDTH    sampled pad level (I per bit)
//  drv_data     in   WIDTH    value the core drives (A per bit)
//  drv_en_n     in   1        drive enable, active low (EN)
//  test_n       in   1        test mode, active low; low forces release (TN)
//  ext_drive    in   1        high when an external agent drives the bus
//  pi           in   1        NAND-tree chain input (PI)
//  o            out  WIDTH    resolved bus value seen by the core (O)
//  e            out  1        pad output buffer enabled (E)
//  zi           out  WIDTH    registered raw pad_in (ZI)
//  po           out  1        NAND-tree chain output (PO)
//  contention   out  1        both sides drove in the previous cycle
//  cont_count   out  CNT_W    saturating count of contention cycles
// BEHAVIOUR
//  Reset (sync): state=IDLE, o=0, e=0, zi=0, po=1, contention=0, cont_count=0, keeper=0, turn_cnt=0.
//  req = ~drv_en_n & test_n (combinational request; drive wanted).
//  FSM, turn_cnt counts TURN_CYCLES:
//   IDLE:     e=0. If req: TURN_CYCLES==0 -> DRIVE, else -> TURN_ON, turn_cnt=0.
//   TURN_ON:  e=0. If !req: -> IDLE (abort). Elif turn_cnt==TURN_CYCLES-1: -> DRIVE. Else turn_cnt++.
//   DRIVE:    e=1. If !req: TURN_CYCLES==0 -> IDLE, else -> TURN_OFF, turn_cnt=0.
//   TURN_OFF: e=0. If turn_cnt==TURN_CYCLES-1: -> IDLE. Else turn_cnt++.
//             A new req here is ignored until IDLE.
//  e is registered: it equals 1 exactly in the cycles where registered state==DRIVE.
//  Latency: drv_en_n falling -> e high after TURN_CYCLES+1 edges; rising -> e low after 1 edge.
//  o (registered, 1 cycle latency):
//   Next state==DRIVE: o<=drv_data; keeper<=drv_data.
//   Else if ext_drive: o<=pad_in; keeper<=pad_in.
//   Else: o<=keeper if KEEPER==1, else o<=pad_in.
//  zi <= pad_in every cycle, regardless of state.
//  NAND tree (combinational): n[0]=~(pad_in[0]&pi), n[i]=~(pad_in[i]&n[i-1]).
//   po <= n[WIDTH-1]. The chain ignores state and test_n.
//  Contention:
//   contention <= (state==DRIVE) & ext_drive.
//   cont_count increments by 1 for each such cycle and saturates at 2^CNT_W-1. It never wraps.
//  Edge cases:
//   test_n low in DRIVE: treated as req drop -> TURN_OFF/IDLE.
//   reset mid-turnaround: -> IDLE, e=0 at the next edge, counter and keeper cleared.
//   WIDTH==1: reduces to a single-bit pad cell with FSM; po=~(pad_in[0]&pi).
// TESTING
//  1. Reset held 2 cycles with req=1 -> e=0, o=0, po=1, cont_count=0 at every edge.
//  2. TURN_CYCLES=2, drv_en_n 1->0 at cycle 0, drv_data=8'hA5 -> e=1 from edge 3, o=8'hA5.
//     drv_en_n->1 -> e=0 next edge, state IDLE after 2 more cycles.
//  3. KEEPER=1: drive 8'h3C, release, ext_drive=0, pad_in=8'hFF -> o stays 8'h3C.
//     ext_drive=1 -> o=8'hFF next edge.
//  4. NAND tree, WIDTH=8, pi=1: pad_in=8'hFF -> po=1; pad_in=8'hFE -> po=0.
//     Every single-bit-zero pattern checked against the model.
//  5. CNT_W=2: DRIVE with ext_drive=1 for 5 cycles -> contention=1 each cycle, cont_count 1,2,3,3,3.
//  6. test_n=0 during DRIVE, then reset asserted in TURN_OFF
//     -> e=0 next edge, FSM in IDLE, keeper=0, counter=0.

Source files
------------

// File: rtl/bidir_pad_bank.sv
// bidir_pad_bank
//   A bank of WIDTH registered bidirectional pad cells that share one drive-enable request.
//   The bank adds four things on top of a plain pad cell:
//     - a turnaround FSM that inserts TURN_CYCLES idle cycles when the drive turns on or off,
//     - an optional bus keeper that holds the last resolved value while the bus floats,
//     - a NAND-tree test chain running across all bits,
//     - contention detection with a saturating counter.
//
//   Ports
//     MasterClock  in   1      sole clock; every state update happens on its rising edge
//     reset        in   1      synchronous, active-high
//     pad_in       in   WIDTH  sampled pad level
//     drv_data     in   WIDTH  value the core wants to drive
//     drv_en_n     in   1      drive enable, active low
//     test_n       in   1      test mode, active low; holding it low forces the bank to release
//     ext_drive    in   1      an external agent is driving the bus
//     pi           in   1      NAND-tree chain input
//     o            out  WIDTH  resolved bus value seen by the core (registered)
//     e            out  1      pad output buffer enable (registered)
//     zi           out  WIDTH  registered raw pad_in
//     po           out  1      NAND-tree chain output (registered)
//     contention   out  1      both sides drove in the previous cycle
//     cont_count   out  CNT_W  saturating count of contention cycles
//
//   state    | meaning
//   IDLE     | bus released, waiting for a drive request
//   TURN_ON  | request seen; idle turnaround cycles before enabling the driver
//   DRIVE    | output buffer enabled, drv_data on the bus
//   TURN_OFF | request dropped; idle turnaround cycles, new requests ignored
module bidir_pad_bank #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int KEEPER      = 1,
  parameter int CNT_W       = 8
) (
  input  logic             MasterClock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] drv_data,
  input  logic             drv_en_n,
  input  logic             test_n,
  input  logic             ext_drive,
  input  logic             pi,
  output logic [WIDTH-1:0] o,
  output logic             e,
  output logic [WIDTH-1:0] zi,
  output logic             po,
  output logic             contention,
  output logic [CNT_W-1:0] cont_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } padState_t;

  // A zero-length turnaround never enters TURN_ON/TURN_OFF, so the clamp only
  // keeps the constant in range.
  localparam logic [3:0]       TURN_LAST = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  padState_t  state, nextState;
  logic [3:0] turnCnt, nextTurnCnt;
  logic [WIDTH-1:0] keeper;
  logic       req;
  logic       chainBit;

  assign req = ~drv_en_n & test_n;

  always_comb begin
    nextState   = state;
    nextTurnCnt = turnCnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (TURN_CYCLES == 0) begin
            nextState = DRIVE;
          end else begin
            nextState   = TURN_ON;
            nextTurnCnt = '0;
          end
        end
      end
      TURN_ON: begin
        if (!req)                       nextState   = IDLE;
        else if (turnCnt == TURN_LAST)  nextState   = DRIVE;
        else                            nextTurnCnt = turnCnt + 4'd1;
      end
      DRIVE: begin
        if (!req) begin
          if (TURN_CYCLES == 0) begin
            nextState = IDLE;
          end else begin
            nextState   = TURN_OFF;
            nextTurnCnt = '0;
          end
        end
      end
      TURN_OFF: begin
        // Requests are deliberately ignored until the bus has fully turned around.
        if (turnCnt == TURN_LAST) nextState   = IDLE;
        else                      nextTurnCnt = turnCnt + 4'd1;
      end
      default: nextState = IDLE;
    endcase
  end

  // NAND tree: each stage NANDs its pad bit with the previous stage, seeded by pi.
  always_comb begin
    chainBit = pi;
    for (int i = 0; i < WIDTH; i++) begin
      chainBit = ~(pad_in[i] & chainBit);
    end
  end

  always_ff @(posedge MasterClock) begin
    if (reset) begin
      state      <= IDLE;
      turnCnt    <= '0;
      o          <= '0;
      e          <= 1'b0;
      zi         <= '0;
      po         <= 1'b1;
      contention <= 1'b0;
      cont_count <= '0;
      keeper     <= '0;
    end else begin
      state   <= nextState;
      turnCnt <= nextTurnCnt;
      e       <= (nextState == DRIVE);
      zi      <= pad_in;
      po      <= chainBit;

      if (nextState == DRIVE) begin
        o      <= drv_data;
        keeper <= drv_data;
      end else if (ext_drive) begin
        o      <= pad_in;
        keeper <= pad_in;
      end else begin
        o <= (KEEPER != 0) ? keeper : pad_in;
      end

      contention <= (state == DRIVE) & ext_drive;
      if ((state == DRIVE) && ext_drive && (cont_count != CNT_MAX))
        cont_count <= cont_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bidir_pad_bank.sv
// Bench for bidir_pad_bank. Two instances share the same stimulus:
//   A: TURN_CYCLES=2, KEEPER=1, CNT_W=2
//   B: TURN_CYCLES=0, KEEPER=0, CNT_W=8
// A reference model predicts the outputs of both instances.
// One process compares every output on every falling edge.
// Hand-computed literals taken just after rising edges pin the model itself.
module tb_bidir_pad_bank;

  logic       MasterClock = 1'b0;
  always #5 MasterClock = ~MasterClock;

  logic       reset;
  logic [7:0] pad_in, drv_data;
  logic       drv_en_n, test_n, ext_drive, pi;

  logic [7:0] oA, ziA, oB, ziB;
  logic       eA, poA, contA, eB, poB, contB;
  logic [1:0] cntA;
  logic [7:0] cntB;

  bidir_pad_bank #(.WIDTH(8), .TURN_CYCLES(2), .KEEPER(1), .CNT_W(2)) dutA (
    .MasterClock(MasterClock), .reset(reset), .pad_in(pad_in), .drv_data(drv_data),
    .drv_en_n(drv_en_n), .test_n(test_n), .ext_drive(ext_drive), .pi(pi),
    .o(oA), .e(eA), .zi(ziA), .po(poA), .contention(contA), .cont_count(cntA));

  bidir_pad_bank #(.WIDTH(8), .TURN_CYCLES(0), .KEEPER(0), .CNT_W(8)) dutB (
    .MasterClock(MasterClock), .reset(reset), .pad_in(pad_in), .drv_data(drv_data),
    .drv_en_n(drv_en_n), .test_n(test_n), .ext_drive(ext_drive), .pi(pi),
    .o(oB), .e(eB), .zi(ziB), .po(poB), .contention(contB), .cont_count(cntB));

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model. Phases: 0 released, 1 waiting to drive, 2 driving, 3 waiting to release.
  // The wait phases count the remaining turnaround cycles down to zero.
  localparam int TC   [2] = '{2, 0};
  localparam int KP   [2] = '{1, 0};
  localparam int CMAX [2] = '{3, 255};

  int         ph[2], mLeft[2], mCnt[2];
  logic [7:0] mO[2], mKeep[2];
  logic       mCont[2];
  logic [7:0] mZi;
  logic       mPo;
  logic       mReq, wasDrive;
  bit         checkEn = 0;

  // Closed form of the NAND tree: the highest zero bit forces its stage to 1.
  // The remaining stages then alternate.
  // With no zero bit, eight inversions return pi.
  function automatic logic treeOut(input logic [7:0] p, input logic pin);
    int hi;
    hi = -1;
    for (int i = 0; i < 8; i++) if (!p[i]) hi = i;
    if (hi < 0) return pin;
    return ((7 - hi) % 2) == 0;
  endfunction

  always @(posedge MasterClock) begin
    mReq = !drv_en_n && test_n;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ph[k] = 0; mLeft[k] = 0; mO[k] = 8'h00; mKeep[k] = 8'h00; mCont[k] = 1'b0; mCnt[k] = 0;
      end else begin
        wasDrive = (ph[k] == 2);
        case (ph[k])
          0: if (mReq) begin
               if (TC[k] == 0) ph[k] = 2;
               else begin ph[k] = 1; mLeft[k] = TC[k]; end
             end
          1: if (!mReq) ph[k] = 0;
             else begin mLeft[k]--; if (mLeft[k] == 0) ph[k] = 2; end
          2: if (!mReq) begin
               if (TC[k] == 0) ph[k] = 0;
               else begin ph[k] = 3; mLeft[k] = TC[k]; end
             end
          default: begin mLeft[k]--; if (mLeft[k] == 0) ph[k] = 0; end
        endcase
        if (ph[k] == 2) begin
          mO[k] = drv_data; mKeep[k] = drv_data;
        end else if (ext_drive) begin
          mO[k] = pad_in; mKeep[k] = pad_in;
        end else begin
          mO[k] = (KP[k] != 0) ? mKeep[k] : pad_in;
        end
        mCont[k] = wasDrive && ext_drive;
        if (mCont[k] && mCnt[k] < CMAX[k]) mCnt[k]++;
      end
    end
    mZi = reset ? 8'h00 : pad_in;
    mPo = reset ? 1'b1 : treeOut(pad_in, pi);
    if (reset) checkEn = 1;
  end

  always @(negedge MasterClock) begin
    if (checkEn) begin
      check("A.e",   eA,    ph[0] == 2);
      check("A.o",   oA,    mO[0]);
      check("A.zi",  ziA,   mZi);
      check("A.po",  poA,   mPo);
      check("A.con", contA, mCont[0]);
      check("A.cnt", cntA,  mCnt[0]);
      check("B.e",   eB,    ph[1] == 2);
      check("B.o",   oB,    mO[1]);
      check("B.zi",  ziB,   mZi);
      check("B.po",  poB,   mPo);
      check("B.con", contB, mCont[1]);
      check("B.cnt", cntB,  mCnt[1]);
    end
  end

  task automatic tick();
    @(posedge MasterClock);
    #1;
  endtask

  initial begin
    reset = 1'b1; drv_en_n = 1'b0; test_n = 1'b1; ext_drive = 1'b0;
    pi = 1'b1; pad_in = 8'h00; drv_data = 8'h00;

    // Reset held with a drive request pending.
    repeat (2) begin
      tick();
      check("rst.e", eA, 0); check("rst.o", oA, 0);
      check("rst.po", poA, 1); check("rst.cnt", cntA, 0);
    end

    // Turn-on latency is TURN_CYCLES+1 edges; turn-off latency is one edge.
    reset = 1'b0; drv_en_n = 1'b1; tick();
    drv_en_n = 1'b0; drv_data = 8'hA5;
    tick(); check("on.e1", eA, 0); check("on.eB", eB, 1);
    tick(); check("on.e2", eA, 0);
    tick(); check("on.e3", eA, 1); check("on.o", oA, 8'hA5);
    drv_en_n = 1'b1;
    tick(); check("off.e1", eA, 0);
    tick(); check("off.e2", eA, 0);
    tick(); check("off.e3", eA, 0);
    // Back in IDLE: a new request again takes three edges.
    drv_en_n = 1'b0;
    tick(); check("re.e1", eA, 0);
    tick(); check("re.e2", eA, 0);
    tick(); check("re.e3", eA, 1);

    // Keeper holds the last driven value while the bus floats.
    drv_data = 8'h3C; tick(); check("keep.drv", oA, 8'h3C);
    drv_en_n = 1'b1; ext_drive = 1'b0; pad_in = 8'hFF;
    repeat (3) begin
      tick(); check("keep.hold", oA, 8'h3C); check("keep.B", oB, 8'hFF);
    end
    ext_drive = 1'b1; tick(); check("keep.ext", oA, 8'hFF);

    // NAND tree.
    ext_drive = 1'b0; pi = 1'b1;
    pad_in = 8'hFF; tick(); check("nand.FF", poA, 1);
    pad_in = 8'hFE; tick(); check("nand.FE", poA, 0);
    for (int k = 0; k < 8; k++) begin
      pad_in = ~(8'h01 << k);
      tick(); check("nand.bit", poA, ((7 - k) % 2) == 0);
    end

    // Contention saturates the 2-bit counter.
    reset = 1'b1; tick(); reset = 1'b0;
    drv_en_n = 1'b0; test_n = 1'b1; ext_drive = 1'b0;
    repeat (3) tick();
    check("cont.drive", eA, 1);
    ext_drive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cont.flag", contA, 1);
      check("cont.cnt", cntA, (i + 1 > 3) ? 3 : i + 1);
    end

    // test_n drop in DRIVE, then reset during TURN_OFF.
    ext_drive = 1'b0; test_n = 1'b0;
    tick(); check("tn.e", eA, 0);
    reset = 1'b1;
    tick(); check("rt.e", eA, 0); check("rt.cnt", cntA, 0); check("rt.o", oA, 0);
    reset = 1'b0; test_n = 1'b1; drv_en_n = 1'b1; pad_in = 8'hFF;
    tick(); check("rt.keeper", oA, 0);
    drv_en_n = 1'b0;
    tick(); check("rt.idle1", eA, 0);
    tick(); check("rt.idle2", eA, 0);
    tick(); check("rt.idle3", eA, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) drv_en_n = ~drv_en_n;
      test_n    = ($urandom_range(0, 9) != 0);
      ext_drive = ($urandom_range(0, 2) == 0);
      pad_in    = 8'($urandom);
      drv_data  = 8'($urandom);
      pi        = 1'($urandom);
      tick();
    end

    @(posedge MasterClock);
    @(negedge MasterClock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
